rasterizer_backend_stream: RTL and testbench

// - Per-triangle scan-conversion engine; successor to the single-shot backend rasterizer.
// - Accepts one triangle setup per handshake, walks its inclusive bounding box row by row, and emits only covered pixels.
// - Each emitted pixel carries addr/x/y/depth on a valid/ready stream with full backpressure. Sits between triangle setup and the z-test/framebuffer writer.

---
 rtl/rasterizer_pkg.sv | 30 +++
 rtl/raster_edge_walker.sv | 48 ++++
 rtl/rasterizer_backend_stream.sv | 204 ++++++++++++++++++++
 tb/tb_rasterizer_backend_stream.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rasterizer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rasterizer_pkg : shared types and inside test for the raster backend     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rasterizer_pkg;

  localparam int VEC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [VEC_WIDTH-1:0] x;
    logic signed [VEC_WIDTH-1:0] y;
  } vec2_t;

  // Works on sign/zero flags so it is independent of the edge value width.
  function automatic logic edge_inside(input logic [2:0] neg, input logic [2:0] zero,
                                       input logic inclusive);
    if (inclusive) return ~|neg;
    return ~|(neg | zero);
  endfunction

endpackage
`default_nettype wire

// File: rtl/raster_edge_walker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | raster_edge_walker : incremental accumulator with row-start memory       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module raster_edge_walker #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] delta_x,
  input  logic [WIDTH-1:0] delta_y,
  input  logic             step_x,
  input  logic             step_row,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_row_start;
  logic [WIDTH-1:0] r_dx;
  logic [WIDTH-1:0] r_dy;

  // Two's-complement wrap makes plain unsigned adds correct for signed data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_row_start <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
    end else if (load) begin
      r_acc       <= init;
      r_row_start <= init;
      r_dx        <= delta_x;
      r_dy        <= delta_y;
    end else if (step_row) begin
      r_acc       <= r_row_start + r_dy;
      r_row_start <= r_row_start + r_dy;
    end else if (step_x) begin
      r_acc <= r_acc + r_dx;
    end
  end

  assign value = r_acc;

endmodule
`default_nettype wire

// File: rtl/rasterizer_backend_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rasterizer_backend_stream : bbox walker emitting covered pixels          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rasterizer_backend_stream
  import rasterizer_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int DEPTH_WIDTH       = 16,
  parameter int BUFFER_ADDR_WIDTH = 15,
  parameter int FB_WIDTH          = 160,
  parameter bit INCLUSIVE_EDGES   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0][DATA_WIDTH-1:0]   bb_tl,
  input  logic [1:0][DATA_WIDTH-1:0]   bb_br,
  input  logic [DATA_WIDTH-1:0]        edge0,
  input  logic [DATA_WIDTH-1:0]        edge1,
  input  logic [DATA_WIDTH-1:0]        edge2,
  input  logic [1:0][DATA_WIDTH-1:0]   edge_delta0,
  input  logic [1:0][DATA_WIDTH-1:0]   edge_delta1,
  input  logic [1:0][DATA_WIDTH-1:0]   edge_delta2,
  input  logic [DATA_WIDTH-1:0]        z,
  input  logic [1:0][DATA_WIDTH-1:0]   z_delta,
  input  logic [BUFFER_ADDR_WIDTH-1:0] buffer_addr_start,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUFFER_ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]        out_x,
  output logic [DATA_WIDTH-1:0]        out_y,
  output logic [DEPTH_WIDTH-1:0]       out_depth,
  output logic                         busy,
  output logic                         done
);

  state_t                         r_state;
  logic                           r_in_ready;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_out_valid;
  logic [BUFFER_ADDR_WIDTH-1:0]   r_out_addr;
  logic [DATA_WIDTH-1:0]          r_out_x;
  logic [DATA_WIDTH-1:0]          r_out_y;
  logic [DEPTH_WIDTH-1:0]         r_out_depth;
  logic signed [DATA_WIDTH-1:0]   r_tl_x;
  logic signed [DATA_WIDTH-1:0]   r_tl_y;
  logic signed [DATA_WIDTH-1:0]   r_br_x;
  logic signed [DATA_WIDTH-1:0]   r_br_y;
  logic signed [DATA_WIDTH-1:0]   r_x;
  logic signed [DATA_WIDTH-1:0]   r_y;
  logic [BUFFER_ADDR_WIDTH-1:0]   r_addr;
  logic [BUFFER_ADDR_WIDTH-1:0]   r_jump;

  logic [DATA_WIDTH-1:0] w_edge_init [3];
  logic [DATA_WIDTH-1:0] w_edge_dx   [3];
  logic [DATA_WIDTH-1:0] w_edge_dy   [3];
  logic [DATA_WIDTH-1:0] w_edge      [3];
  logic [2:0]            w_neg;
  logic [2:0]            w_zero;
  logic [DATA_WIDTH-1:0] w_z;
  logic                  w_accept;
  logic                  w_step;
  logic                  w_x_more;
  logic                  w_step_x;
  logic                  w_step_row;
  logic                  w_inside;

  assign w_edge_init[0] = edge0;
  assign w_edge_init[1] = edge1;
  assign w_edge_init[2] = edge2;
  assign w_edge_dx[0]   = edge_delta0[0];
  assign w_edge_dx[1]   = edge_delta1[0];
  assign w_edge_dx[2]   = edge_delta2[0];
  assign w_edge_dy[0]   = edge_delta0[1];
  assign w_edge_dy[1]   = edge_delta1[1];
  assign w_edge_dy[2]   = edge_delta2[1];

  assign w_accept   = (r_state == IDLE) && in_valid && r_in_ready;
  assign w_step     = (r_state == SCAN) && (!r_out_valid || out_ready);
  assign w_x_more   = (r_x < r_br_x);
  assign w_step_x   = w_step && w_x_more;
  assign w_step_row = w_step && !w_x_more;

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    raster_edge_walker #(.WIDTH(DATA_WIDTH)) u_walker (
      .clk      (clk),
      .rst      (rst),
      .load     (w_accept),
      .init     (w_edge_init[gi]),
      .delta_x  (w_edge_dx[gi]),
      .delta_y  (w_edge_dy[gi]),
      .step_x   (w_step_x),
      .step_row (w_step_row),
      .value    (w_edge[gi])
    );
    assign w_neg[gi]  = w_edge[gi][DATA_WIDTH-1];
    assign w_zero[gi] = (w_edge[gi] == '0);
  end

  raster_edge_walker #(.WIDTH(DATA_WIDTH)) u_z_walker (
    .clk      (clk),
    .rst      (rst),
    .load     (w_accept),
    .init     (z),
    .delta_x  (z_delta[0]),
    .delta_y  (z_delta[1]),
    .step_x   (w_step_x),
    .step_row (w_step_row),
    .value    (w_z)
  );

  assign w_inside = edge_inside(w_neg, w_zero, INCLUSIVE_EDGES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_depth <= '0;
      r_tl_x      <= '0;
      r_tl_y      <= '0;
      r_br_x      <= '0;
      r_br_y      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_jump      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tl_x     <= bb_tl[0];
            r_tl_y     <= bb_tl[1];
            r_br_x     <= bb_br[0];
            r_br_y     <= bb_br[1];
            r_x        <= bb_tl[0];
            r_y        <= bb_tl[1];
            r_addr     <= buffer_addr_start;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          // Address step from the last pixel of a row to the first of the next.
          r_jump <= BUFFER_ADDR_WIDTH'(FB_WIDTH) - BUFFER_ADDR_WIDTH'(r_br_x - r_tl_x);
          if ((r_br_x < r_tl_x) || (r_br_y < r_tl_y)) r_state <= DRAIN;
          else                                        r_state <= SCAN;
        end
        SCAN: begin
          if (w_step) begin
            r_out_valid <= w_inside;
            if (w_inside) begin
              r_out_addr  <= r_addr;
              r_out_x     <= r_x;
              r_out_y     <= r_y;
              r_out_depth <= w_z[DEPTH_WIDTH-1:0];
            end
            if (w_x_more) begin
              r_x    <= r_x + 1'b1;
              r_addr <= r_addr + 1'b1;
            end else begin
              r_x    <= r_tl_x;
              r_y    <= r_y + 1'b1;
              r_addr <= r_addr + r_jump;
              if (r_y == r_br_y) r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!r_out_valid || out_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_depth = r_out_depth;

endmodule
`default_nettype wire

// File: tb/tb_rasterizer_backend_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rasterizer_backend_stream : scoreboard bench, exclusive and inclusive |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rasterizer_backend_stream;

  localparam int DW  = 16;
  localparam int AW  = 15;
  localparam int FBW = 160;

  typedef struct {
    int tlx, tly, brx, bry;
    int e0, e1, e2;
    int dx0, dy0, dx1, dy1, dx2, dy2;
    int z, zdx, zdy;
    int addr;
  } tri_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid0 = 1'b0;
  logic in_valid1 = 1'b0;
  logic out_ready = 1'b1;
  logic [1:0][DW-1:0] bb_tl = '0, bb_br = '0, ed0 = '0, ed1 = '0, ed2 = '0, zd = '0;
  logic [DW-1:0] e0 = '0, e1 = '0, e2 = '0, zv = '0;
  logic [AW-1:0] astart = '0;

  logic in_ready0, out_valid0, busy0, done0;
  logic in_ready1, out_valid1, busy1, done1;
  logic [AW-1:0] out_addr0, out_addr1;
  logic [DW-1:0] out_x0, out_y0, out_depth0, out_x1, out_y1, out_depth1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  int acc_cyc = 0;
  int dcnt[2];
  int dcyc[2];
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rasterizer_backend_stream #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DW), .BUFFER_ADDR_WIDTH(AW),
                              .FB_WIDTH(FBW), .INCLUSIVE_EDGES(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .bb_tl(bb_tl), .bb_br(bb_br), .edge0(e0), .edge1(e1), .edge2(e2),
    .edge_delta0(ed0), .edge_delta1(ed1), .edge_delta2(ed2), .z(zv), .z_delta(zd),
    .buffer_addr_start(astart), .out_valid(out_valid0), .out_ready(out_ready),
    .out_addr(out_addr0), .out_x(out_x0), .out_y(out_y0), .out_depth(out_depth0),
    .busy(busy0), .done(done0)
  );

  rasterizer_backend_stream #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DW), .BUFFER_ADDR_WIDTH(AW),
                              .FB_WIDTH(FBW), .INCLUSIVE_EDGES(1'b1)) dut_inc (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .bb_tl(bb_tl), .bb_br(bb_br), .edge0(e0), .edge1(e1), .edge2(e2),
    .edge_delta0(ed0), .edge_delta1(ed1), .edge_delta2(ed2), .z(zv), .z_delta(zd),
    .buffer_addr_start(astart), .out_valid(out_valid1), .out_ready(out_ready),
    .out_addr(out_addr1), .out_x(out_x1), .out_y(out_y1), .out_depth(out_depth1),
    .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int s16(input int v);
    logic signed [15:0] s;
    s = v[15:0];
    return int'(s);
  endfunction

  function automatic bit ins(input int v, input bit inc);
    return inc ? (v >= 0) : (v > 0);
  endfunction

  // Reference: evaluate every bbox pixel directly from its offset to the corner.
  task automatic build_expect(input tri_t t, input bit sel);
    for (int y = t.tly; y <= t.bry; y++) begin
      for (int x = t.tlx; x <= t.brx; x++) begin
        int ex, ey, a, d;
        bit ok;
        logic [63:0] p;
        ex = x - t.tlx;
        ey = y - t.tly;
        ok = ins(s16(t.e0 + ex * t.dx0 + ey * t.dy0), sel) &&
             ins(s16(t.e1 + ex * t.dx1 + ey * t.dy1), sel) &&
             ins(s16(t.e2 + ex * t.dx2 + ey * t.dy2), sel);
        if (ok) begin
          a = t.addr + ey * FBW + ex;
          d = t.z + ex * t.zdx + ey * t.zdy;
          p = {1'b1, a[14:0], x[15:0], y[15:0], d[15:0]};
          if (sel) q1.push_back(p);
          else     q0.push_back(p);
        end
      end
    end
  endtask

  task automatic monitor(input bit sel);
    logic [63:0] got, prev;
    bit stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        got = sel ? {out_valid1, out_addr1, out_x1, out_y1, out_depth1}
                  : {out_valid0, out_addr0, out_x0, out_y0, out_depth0};
        if (stall) chk("stall_hold", got, prev);
        if (sel ? done1 : done0) begin
          dcnt[sel] = dcnt[sel] + 1;
          dcyc[sel] = cyc;
        end
        if (got[63] && out_ready) begin
          if ((sel ? q1.size() : q0.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got %0h expected no pixel", got);
          end else begin
            chk("pixel", got, sel ? q1.pop_front() : q0.pop_front());
          end
        end
        stall = got[63] && !out_ready;
        prev  = got;
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  function automatic tri_t mk(input int tlx, tly, brx, bry, e);
    tri_t t;
    t = '{default: 0};
    t.tlx = tlx; t.tly = tly; t.brx = brx; t.bry = bry;
    t.e0 = e; t.e1 = e; t.e2 = e;
    return t;
  endfunction

  task automatic issue_tri(input tri_t t, input bit sel);
    int n;
    build_expect(t, sel);
    @(negedge clk);
    bb_tl[0] = t.tlx[15:0]; bb_tl[1] = t.tly[15:0];
    bb_br[0] = t.brx[15:0]; bb_br[1] = t.bry[15:0];
    e0 = t.e0[15:0]; e1 = t.e1[15:0]; e2 = t.e2[15:0];
    ed0[0] = t.dx0[15:0]; ed0[1] = t.dy0[15:0];
    ed1[0] = t.dx1[15:0]; ed1[1] = t.dy1[15:0];
    ed2[0] = t.dx2[15:0]; ed2[1] = t.dy2[15:0];
    zv = t.z[15:0]; zd[0] = t.zdx[15:0]; zd[1] = t.zdy[15:0];
    astart = t.addr[14:0];
    n = 0;
    while (!(sel ? in_ready1 : in_ready0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {63'd0, sel ? in_ready1 : in_ready0}, 64'd1);
    if (sel) in_valid1 = 1'b1;
    else     in_valid0 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    acc_cyc = cyc;
    // Scramble live inputs: the engine must work from its latched copy.
    bb_tl = {$urandom, $urandom}; bb_br = {$urandom, $urandom};
    e0 = 16'($urandom); e1 = 16'($urandom); e2 = 16'($urandom); zv = 16'($urandom);
    ed0 = {$urandom, $urandom}; zd = {$urandom, $urandom}; astart = 15'($urandom);
  endtask

  task automatic run_tri(input tri_t t, input bit sel, input int lat);
    int base, n;
    base = dcnt[sel];
    issue_tri(t, sel);
    n = 0;
    while (dcnt[sel] == base && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(dcnt[sel] - base), 64'd1);
    chk("all_pixels_out", 64'(sel ? q1.size() : q0.size()), 64'd0);
    chk("in_ready_after", {63'd0, sel ? in_ready1 : in_ready0}, 64'd1);
    if (lat >= 0) chk("done_latency", 64'(dcyc[sel] - acc_cyc), 64'(lat));
  endtask

  function automatic int rs(input int lo, hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  function automatic tri_t rand_tri();
    tri_t t;
    t = mk(rs(0, 20), rs(0, 20), 0, 0, 0);
    t.brx = t.tlx + rs(0, 6); t.bry = t.tly + rs(0, 5);
    t.e0 = rs(-20, 20); t.e1 = rs(-20, 20); t.e2 = rs(-5, 30);
    t.dx0 = rs(-5, 5); t.dy0 = rs(-5, 5); t.dx1 = rs(-5, 5);
    t.dy1 = rs(-5, 5); t.dx2 = rs(-5, 5); t.dy2 = rs(-5, 5);
    t.z = rs(0, 2000); t.zdx = rs(-30, 30); t.zdy = rs(-30, 30);
    t.addr = rs(0, 32767);
    return t;
  endfunction

  initial begin
    tri_t t;
    int n;
    dcnt[0] = 0; dcnt[1] = 0; dcyc[0] = 0; dcyc[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_done", {63'd0, done0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_fields", {1'b0, out_addr0, out_x0, out_y0, out_depth0}, 64'd0);

    ready_mode = 0;
    t = mk(0, 0, 3, 3, 1);
    run_tri(t, 1'b0, -1);
    t.e0 = 0;
    run_tri(t, 1'b0, -1);
    run_tri(t, 1'b1, -1);

    t = mk(0, 0, 3, 0, 1);
    t.e0 = 2; t.dx0 = -1; t.z = 10; t.zdx = 5;
    run_tri(t, 1'b0, -1);

    ready_mode = 1;
    t = mk(2, 3, 9, 10, 5);
    t.addr = 100; t.z = 1000; t.zdx = 3; t.zdy = -7;
    run_tri(t, 1'b0, -1);

    t = mk(4, 4, 3, 6, 1);
    run_tri(t, 1'b0, 2);
    t = mk(7, 7, 7, 7, 1);
    t.addr = 32767;
    run_tri(t, 1'b0, -1);

    for (int i = 0; i < 8; i++) run_tri(rand_tri(), 1'b0, -1);

    ready_mode = 2;
    @(posedge clk);
    t = mk(0, 0, 7, 7, 3);
    issue_tri(t, 1'b0);
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("stalled_before_rst", {63'd0, out_valid0}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy0}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, in_ready0}, 64'd1);
    q0.delete();
    ready_mode = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    t = mk(1, 2, 6, 5, 4);
    t.dx0 = -1; t.dy1 = -1; t.z = 77; t.zdx = 2; t.zdy = 9; t.addr = 500;
    run_tri(t, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
